// File: rtl/dsc_op_sequencer.sv
// Operand/clear/run/result sequencer in front of the DSC multi-input multiplier core.
// Optional DSC_SEQ_STATS_EN adds saturating op, cycle and truncation counters.
module dsc_op_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 2,
  parameter int WXIP1      = NUM_INPUTS*DATA_WIDTH+1
) (
  input  logic                             gclk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [WXIP1-1:0]                 cyc_budget,
  output logic                             core_rst,
  output logic                             core_en,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_in,
  input  logic [WXIP1-1:0]                 core_data_out,
  input  logic                             core_op_finished,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WXIP1-1:0]                 out_data,
  output logic [WXIP1-1:0]                 out_cycles,
  output logic                             out_truncated
`ifdef DSC_SEQ_STATS_EN
  ,
  output logic [31:0]                      stat_ops,
  output logic [47:0]                      stat_cycles,
  output logic [31:0]                      stat_trunc
`endif
);

  localparam int OPW = NUM_INPUTS*DATA_WIDTH;
  localparam logic [WXIP1-1:0] ONE = {{(WXIP1-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [OPW-1:0]   r_operands;
  logic [WXIP1-1:0] r_budget;
  logic [WXIP1-1:0] r_cnt;
  logic [WXIP1-1:0] r_outData;
  logic [WXIP1-1:0] r_outCycles;
  logic             r_outTrunc;
  logic [WXIP1-1:0] w_n;
  logic             w_runExit;
  logic             w_accept;

  assign w_n       = r_cnt + ONE;
  // Stop on completion, on reaching a nonzero budget, or when the counter would saturate.
  assign w_runExit = core_op_finished || ((r_budget != '0) && (w_n == r_budget)) || (w_n == '1);
  assign w_accept  = in_valid && in_ready;

  assign in_ready      = (r_state == S_IDLE) && !rst;
  assign core_rst      = (r_state == S_IDLE) || (r_state == S_CLEAR);
  assign core_en       = (r_state == S_RUN);
  assign out_valid     = (r_state == S_DONE);
  assign core_data_in  = r_operands;
  assign out_data      = r_outData;
  assign out_cycles    = r_outCycles;
  assign out_truncated = r_outTrunc;

  always_ff @(posedge gclk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nextState = S_CLEAR;
      S_CLEAR: w_nextState = S_RUN;
      S_RUN:   if (w_runExit) w_nextState = S_DONE;
      S_DONE:  if (out_ready) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      r_operands  <= '0;
      r_budget    <= '0;
      r_cnt       <= '0;
      r_outData   <= '0;
      r_outCycles <= '0;
      r_outTrunc  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_accept) begin
        r_operands <= in_data;
        r_budget   <= cyc_budget;
      end
      if (r_state == S_CLEAR) r_cnt <= '0;
      if (r_state == S_RUN) begin
        r_cnt <= w_n;
        if (w_runExit) begin
          r_outData   <= core_data_out;
          r_outCycles <= w_n;
          r_outTrunc  <= !core_op_finished;
        end
      end
    end
  end

`ifdef DSC_SEQ_STATS_EN
  logic [31:0] r_statOps;
  logic [47:0] r_statCycles;
  logic [31:0] r_statTrunc;
  logic [32:0] w_opsSum;
  logic [48:0] w_cyclesSum;
  logic [32:0] w_truncSum;
  logic        w_runDone;

  assign w_runDone   = (r_state == S_RUN) && w_runExit;
  assign w_opsSum    = {1'b0, r_statOps} + 33'd1;
  assign w_cyclesSum = {1'b0, r_statCycles} + 49'(w_n);
  assign w_truncSum  = {1'b0, r_statTrunc} + {32'd0, !core_op_finished};

  // A carry out of any sum means the counter is pinned at all-ones.
  always_ff @(posedge gclk) begin
    if (rst) begin
      r_statOps    <= '0;
      r_statCycles <= '0;
      r_statTrunc  <= '0;
    end else if (w_runDone) begin
      r_statOps    <= w_opsSum[32]    ? '1 : w_opsSum[31:0];
      r_statCycles <= w_cyclesSum[48] ? '1 : w_cyclesSum[47:0];
      r_statTrunc  <= w_truncSum[32]  ? '1 : w_truncSum[31:0];
    end
  end

  assign stat_ops    = r_statOps;
  assign stat_cycles = r_statCycles;
  assign stat_trunc  = r_statTrunc;
`endif

endmodule

// File: tb/tb_dsc_op_sequencer.sv
// Bench for dsc_op_sequencer: core stub, directed vector table, random ops vs. a min()-based model.
// Build with DSC_SEQ_STATS_EN defined to also check the statistics counters.
module tb_dsc_op_sequencer;

  localparam int DW = 8;
  localparam int NI = 2;
  localparam int OPW = DW*NI;
  localparam int WX = OPW+1;

  logic           gclk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_data;
  logic [WX-1:0]  cyc_budget;
  logic           core_rst;
  logic           core_en;
  logic [OPW-1:0] core_data_in;
  logic [WX-1:0]  core_data_out;
  logic           core_op_finished;
  logic           out_valid;
  logic           out_ready;
  logic [WX-1:0]  out_data;
  logic [WX-1:0]  out_cycles;
  logic           out_truncated;
`ifdef DSC_SEQ_STATS_EN
  logic [31:0]    stat_ops;
  logic [47:0]    stat_cycles;
  logic [31:0]    stat_trunc;
`endif

  int assertCount = 0;
  int failCount = 0;

  dsc_op_sequencer #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) dut (
    .gclk(gclk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .cyc_budget(cyc_budget), .core_rst(core_rst),
    .core_en(core_en), .core_data_in(core_data_in), .core_data_out(core_data_out),
    .core_op_finished(core_op_finished), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cycles(out_cycles), .out_truncated(out_truncated)
`ifdef DSC_SEQ_STATS_EN
    , .stat_ops(stat_ops), .stat_cycles(stat_cycles), .stat_trunc(stat_trunc)
`endif
  );

  always #5 gclk = ~gclk;

  // Core stub: counts enabled cycles since its clear; at run cycle k it outputs k+stubBase
  // and raises op_finished when k equals stubFinishAt (0 = never). Outside RUN it emits noise.
  logic [WX-1:0] stubBase;
  logic [WX-1:0] stubFinishAt;
  logic          stubNoise;
  logic [WX-1:0] stubDone;
  logic [WX-1:0] stubK;

  always @(posedge gclk) begin
    if (core_rst)     stubDone <= '0;
    else if (core_en) stubDone <= stubDone + 1'b1;
  end

  assign stubK            = stubDone + 1'b1;
  assign core_data_out    = stubK + stubBase;
  assign core_op_finished = core_en ? ((stubFinishAt != '0) && (stubK == stubFinishAt)) : stubNoise;

  typedef struct {
    logic [OPW-1:0] operands;
    logic [WX-1:0]  budget;
    logic [WX-1:0]  finishAt;
    logic [WX-1:0]  base;
    int             hold;
    int             expCycles;
    logic           expTrunc;
    logic [WX-1:0]  expData;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the run length is the smallest of the finish point, the budget and the
  // saturation value; it is truncated unless the finish point itself set that length.
  task automatic modelOp(input logic [WX-1:0] budget, input logic [WX-1:0] finishAt,
                         input logic [WX-1:0] base, output int expCycles,
                         output logic expTrunc, output logic [WX-1:0] expData);
    int n;
    n = (1 << WX) - 1;
    if (finishAt != 0 && int'(finishAt) < n) n = int'(finishAt);
    if (budget != 0 && int'(budget) < n) n = int'(budget);
    expCycles = n;
    expTrunc  = !(finishAt != 0 && int'(finishAt) == n);
    expData   = WX'(n) + base;
  endtask

  task automatic applyStimulus(input logic [OPW-1:0] ops, input logic [WX-1:0] budget,
                               input logic [WX-1:0] finishAt, input logic [WX-1:0] base,
                               input int hold, input int expCycles, input logic expTrunc,
                               input logic [WX-1:0] expData);
    int edges;
    stubBase     = base;
    stubFinishAt = finishAt;
    checkOutput("in_ready before accept", in_ready, 1);
    in_data    = ops;
    cyc_budget = budget;
    in_valid   = 1'b1;
    @(posedge gclk); #1;
    edges      = 1;
    in_valid   = 1'b0;
    in_data    = OPW'($urandom);
    cyc_budget = WX'($urandom);
    checkOutput("clear rst/en/ready", {core_rst, core_en, in_ready}, 3'b100);
    checkOutput("core_data_in latched", core_data_in, ops);
    while (!out_valid && edges < 300) begin
      @(posedge gclk); #1;
      edges++;
      if (!out_valid) checkOutput("run rst/en", {core_rst, core_en}, 2'b01);
    end
    if (!out_valid) begin
      checkOutput("out_valid timeout", 0, 1);
      return;
    end
    checkOutput("latency", edges, expCycles + 2);
    checkOutput("out_data", out_data, expData);
    checkOutput("out_cycles", out_cycles, expCycles);
    checkOutput("out_truncated", out_truncated, expTrunc);
    checkOutput("done en/rst/ready", {core_en, core_rst, in_ready}, 3'b000);
    in_valid = 1'b1;
    in_data  = ~ops;
    for (int h = 0; h < hold; h++) begin
      @(posedge gclk); #1;
      checkOutput("backpressure hold", {out_valid, in_ready, out_truncated, out_cycles, out_data},
                  {1'b1, 1'b0, expTrunc, WX'(expCycles), expData});
      checkOutput("backpressure operands", core_data_in, ops);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge gclk); #1;
    out_ready = 1'b0;
    checkOutput("after handshake ready/valid", {in_ready, out_valid}, 2'b10);
  endtask

  task automatic applyVec(input vec_t v);
    applyStimulus(v.operands, v.budget, v.finishAt, v.base, v.hold, v.expCycles, v.expTrunc, v.expData);
  endtask

  initial begin
    vec_t  v;
    logic  sawValid;
    int    expC;
    logic  expT;
    logic [WX-1:0] expD;

    vecs[0] = '{{8'd5, 8'd3}, 17'd0,  17'd15, 17'd0,      0, 15, 1'b0, 17'd15};
    vecs[1] = '{{8'd5, 8'd3}, 17'd10, 17'd15, 17'h1FFFF,  0, 10, 1'b1, 17'd9};
    vecs[2] = '{{8'd7, 8'd9}, 17'd15, 17'd15, 17'd0,      0, 15, 1'b0, 17'd15};
    vecs[3] = '{{8'd1, 8'd2}, 17'd1,  17'd15, 17'd0,      0, 1,  1'b1, 17'd1};
    vecs[4] = '{{8'hAA, 8'h55}, 17'd0, 17'd6, 17'd100,    5, 6,  1'b0, 17'd106};
    vecs[5] = '{{8'h12, 8'h34}, 17'd7, 17'd0, 17'h20,     2, 7,  1'b1, 17'h27};
    vecs[6] = '{{8'hFF, 8'hFF}, 17'd0, 17'd1, 17'd0,      1, 1,  1'b0, 17'd1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; cyc_budget = '0; out_ready = 1'b0;
    stubBase = '0; stubFinishAt = '0; stubNoise = 1'b0;
    repeat (2) @(posedge gclk);
    #1;
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset core_rst/en/valid", {core_rst, core_en, out_valid}, 3'b100);
    checkOutput("reset out regs", {out_truncated, out_cycles, out_data}, '0);
    checkOutput("reset operands", core_data_in, 0);
    rst = 1'b0;
    @(posedge gclk); #1;
    checkOutput("ready after release", in_ready, 1);

    applyVec(vecs[0]);
    applyVec(vecs[1]);
`ifdef DSC_SEQ_STATS_EN
    checkOutput("stat_ops", stat_ops, 2);
    checkOutput("stat_cycles", stat_cycles, 25);
    checkOutput("stat_trunc", stat_trunc, 1);
`endif
    for (int i = 2; i < 7; i++) applyVec(vecs[i]);

    for (int i = 0; i < 40; i++) begin
      v.operands = OPW'($urandom);
      v.budget   = WX'($urandom_range(0, 40));
      v.finishAt = WX'($urandom_range(0, 40));
      if (v.budget == 0 && v.finishAt == 0) v.budget = WX'($urandom_range(1, 40));
      v.base     = WX'($urandom);
      v.hold     = $urandom_range(0, 3);
      stubNoise  = 1'($urandom_range(0, 1));
      modelOp(v.budget, v.finishAt, v.base, expC, expT, expD);
      v.expCycles = expC;
      v.expTrunc  = expT;
      v.expData   = expD;
      applyVec(v);
    end
    stubNoise = 1'b0;

    // Reset during RUN cycle 4 of an unbounded op must discard it.
    stubFinishAt = '0;
    in_data = 16'hBEEF; cyc_budget = '0; in_valid = 1'b1;
    @(posedge gclk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge gclk);
    #1;
    checkOutput("mid-run core_en", core_en, 1);
    rst = 1'b1;
    @(posedge gclk); #1;
    checkOutput("mid-run reset rst/en/ready/valid", {core_rst, core_en, in_ready, out_valid}, 4'b1000);
    checkOutput("mid-run reset out regs", {out_truncated, out_cycles, out_data}, '0);
    checkOutput("mid-run reset operands", core_data_in, 0);
`ifdef DSC_SEQ_STATS_EN
    checkOutput("stats cleared", {stat_ops, stat_cycles, stat_trunc}, '0);
`endif
    rst = 1'b0;
    sawValid = 1'b0;
    repeat (20) begin
      @(posedge gclk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("no out_valid after reset", sawValid, 0);
    applyVec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
